pattern_scan_ctrl: RTL and testbench
====================================

Name: pattern_scan_ctrl

Overview:
Sequencing controller that accepts parallel words over a valid/ready handshake and serialises them MSB-first into a built-in overlapping pattern detector (default pattern 1001). The bit history is kept across word boundaries, so the serial stream is continuous. The block counts matches and reports per-word results. It sits between a word-wide producer and the serial FSM detectors, and replaces hand-driven bit stimulus.

Parameters:
DATA_W, 8, width of each accepted word (>=2)
PAT_W, 4, pattern length in bits (2..DATA_W)
PATTERN, 4'b1001, pattern to detect; leftmost bit is the earliest in time
CNT_W, 8, width of the saturating match counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  producer has a word
in_data  input  DATA_W  word to scan
in_ready  output  1  block can accept a word
clear_cnt  input  1  synchronous clear of match_cnt
bit_out  output  1  serial bit currently being scanned
busy  output  1  word in progress (SHIFT or DONE)
match  output  1  registered one-cycle pulse per pattern hit
done  output  1  one-cycle pulse at end of each word
word_match  output  1  any hit in the current word; valid when done=1
match_cnt  output  CNT_W  total hits, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, in_ready=1, busy=0, match=0, done=0, word_match=0, match_cnt=0, bit_out=0, history=0, fill count=0. rst has priority over every other input, including in mid-word. A word in progress is discarded without a done pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. When in_valid&&in_ready, in_data is loaded into the shift register, the bit index is set to DATA_W-1, the word_match flag is cleared, and the FSM goes to SHIFT.
- SHIFT: in_ready=0. bit_out is the shift register MSB, driven from a register. On each edge the bit enters the history and the shift register shifts left. After DATA_W SHIFT cycles the FSM goes to DONE.
- DONE: lasts exactly one cycle. done=1 and word_match is valid. The FSM then goes to IDLE.
- Throughput: DATA_W+2 cycles per word. Latency from acceptance to done is DATA_W+1 cycles.
- Detection: hit = ({history[PAT_W-2:0], bit_out} == PATTERN) && (fill >= PAT_W-1).
  - fill saturates at PAT_W-1.
  - This rule blocks false hits from the zero-initialised history after reset.
  - Detection is overlapping. History is never cleared between words, only by rst.
- Hit timing: a hit registers match=1 in the cycle after the bit is presented (Moore-style). A hit on the last bit therefore shows in the DONE cycle.
- Same edge as a hit: the word_match flag is set, and match_cnt increments unless it is already all-ones, where it holds (saturates).
- clear_cnt: match_cnt <= 0 on that edge. If a hit occurs on the same edge, match_cnt <= 1 (the hit is counted after the clear).
- Input rules: in_data is ignored outside the accept cycle. in_valid may stay high; a new word is taken only in IDLE.

Optional Feature:
Macro: PSC_ABORT_EN.
- Defined: the block gains input port abort (1 bit).
  - abort=1 during SHIFT sends the FSM to IDLE on the next edge and clears history and fill.
  - No done pulse. match_cnt is kept.
  - abort in IDLE or DONE has no effect.
- Undefined: no abort port. Every accepted word always runs to DONE.

Test Plan:
- Reset, then word 0x99 (10011001) -> match pulses after bits 3 and 7 (second one in the DONE cycle); done with word_match=1; match_cnt=2.
- Word 0x92 (10010010) after reset -> overlapping hits at bits 3 and 6; match_cnt=2.
- Word 0x01 then 0x20 -> first done has word_match=0; hit spans the word boundary at the second word's bit 2; second done has word_match=1; match_cnt=1.
- CNT_W=2, feed 0x99 twice -> match_cnt reaches 3 and holds. Then clear_cnt asserted on the same edge as a hit -> match_cnt=1.
- Handshake: in_valid held high continuously -> in_ready=1 only in IDLE; one word accepted every DATA_W+2 cycles; no word lost or duplicated. Also assert rst at bit 4 of a word -> all outputs at reset values the next cycle; no done pulse.
- With PSC_ABORT_EN: abort at bit 2 of 0x99 -> IDLE next cycle, no done, match_cnt unchanged. Then 0x39 (00111001) -> exactly 1 hit; the history was cleared, so the aborted prefix cannot combine with new bits.

Source files
------------

// File: rtl/pattern_scan_ctrl_if.sv
// Word-wide valid/ready handshake between a producer and pattern_scan_ctrl.
// The producer drives the master modport; the scanner uses the slave modport.
interface pattern_scan_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Accepts words over a valid/ready handshake and scans them MSB-first through an overlapping
// PATTERN detector whose bit history spans word boundaries. Optional macro PSC_ABORT_EN adds abort.
module pattern_scan_ctrl #(
  parameter int               DATA_W  = 8,
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
  parameter int               CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  pattern_scan_ctrl_if.slave bus,
  input  logic               clear_cnt,
`ifdef PSC_ABORT_EN
  input  logic               abort,
`endif
  output logic               bit_out,
  output logic               busy,
  output logic               match,
  output logic               done,
  output logic               word_match,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int                IDX_W     = $clog2(DATA_W);
  localparam int                FILL_W    = $clog2(PAT_W);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [DATA_W-1:0]  shreg;
  logic [IDX_W-1:0]   bit_idx;
  logic [PAT_W-2:0]   history;
  logic [FILL_W-1:0]  fill;
  logic [PAT_W-1:0]   window;
  logic               abort_req;
  logic               hit;

`ifdef PSC_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // The bit under scan is the shift-register MSB; an aborted bit is dropped, never counted.
  assign bit_out = shreg[DATA_W-1];
  assign window  = {history, bit_out};
  assign hit     = (state == SHIFT) && !abort_req && (window == PATTERN) && (fill == FILL_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every state element, datapath included, is written with <= so all of them
      // update together from the values seen before this edge; shreg is reset because it drives bit_out.
      state        <= IDLE;
      bus.in_ready <= 1'b1;
      busy         <= 1'b0;
      match        <= 1'b0;
      done         <= 1'b0;
      word_match   <= 1'b0;
      match_cnt    <= '0;
      shreg        <= '0;
      bit_idx      <= '0;
      history      <= '0;
      fill         <= '0;
    end else begin
      match <= hit;
      done  <= 1'b0;

      // A clear and a hit on the same edge leave exactly that one hit counted.
      if (clear_cnt)
        match_cnt <= hit ? CNT_W'(1) : '0;
      else if (hit && (match_cnt != '1))
        match_cnt <= match_cnt + CNT_W'(1);

      if (hit)
        word_match <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            shreg        <= bus.in_data;
            bit_idx      <= IDX_LAST;
            word_match   <= 1'b0;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
            state        <= SHIFT;
          end
        end

        SHIFT: begin
          if (abort_req) begin
            state        <= IDLE;
            bus.in_ready <= 1'b1;
            busy         <= 1'b0;
            shreg        <= '0;
            history      <= '0;
            fill         <= '0;
          end else begin
            history <= window[PAT_W-2:0];
            if (fill != FILL_FULL)
              fill <= fill + FILL_W'(1);
            shreg <= {shreg[DATA_W-2:0], 1'b0};
            if (bit_idx == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              bit_idx <= bit_idx - IDX_W'(1);
            end
          end
        end

        DONE: begin
          state        <= IDLE;
          bus.in_ready <= 1'b1;
          busy         <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl: directed vector table, mid-word reset/abort
// sequences and random words checked against a bit-stream reference model.
module tb_pattern_scan_ctrl;

  localparam int               PAT_W = 4;
  localparam logic [PAT_W-1:0] PAT   = 4'b1001;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear_cnt;
  logic       in_valid;
  logic [7:0] in_data;
`ifdef PSC_ABORT_EN
  logic       abort;
`endif

  logic       bit_out,  busy,  match,  done,  word_match;
  logic [7:0] match_cnt;
  logic       bit_out2, busy2, match2, done2, word_match2;
  logic [1:0] match_cnt2;

  int n_cmp = 0;
  int n_err = 0;

  logic stream[$];
  int   cnt;
  int   cnt2;

  always #5 clk = ~clk;

  pattern_scan_ctrl_if #(.DATA_W(8)) bus ();
  pattern_scan_ctrl_if #(.DATA_W(8)) bus2 ();

  assign bus.in_valid  = in_valid;
  assign bus.in_data   = in_data;
  assign bus2.in_valid = in_valid;
  assign bus2.in_data  = in_data;

  pattern_scan_ctrl #(.DATA_W(8), .PAT_W(4), .PATTERN(4'b1001), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clear_cnt  (clear_cnt),
`ifdef PSC_ABORT_EN
    .abort      (abort),
`endif
    .bit_out    (bit_out),
    .busy       (busy),
    .match      (match),
    .done       (done),
    .word_match (word_match),
    .match_cnt  (match_cnt)
  );

  pattern_scan_ctrl #(.DATA_W(8), .PAT_W(4), .PATTERN(4'b1001), .CNT_W(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus2),
    .clear_cnt  (clear_cnt),
`ifdef PSC_ABORT_EN
    .abort      (abort),
`endif
    .bit_out    (bit_out2),
    .busy       (busy2),
    .match      (match2),
    .done       (done2),
    .word_match (word_match2),
    .match_cnt  (match_cnt2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_flags(input logic rdy, input logic bsy, input logic dn, input logic m);
    check("in_ready",  bus.in_ready,  rdy);
    check("busy",      busy,          bsy);
    check("done",      done,          dn);
    check("match",     match,         m);
    check("in_ready2", bus2.in_ready, rdy);
    check("busy2",     busy2,         bsy);
    check("done2",     done2,         dn);
    check("match2",    match2,        m);
  endtask

  task automatic check_cnt();
    check("match_cnt",  match_cnt,  cnt);
    check("match_cnt2", match_cnt2, cnt2);
  endtask

  // Reference: the serial stream since the last reset/abort; a hit is the latest PAT_W bits equal to PAT.
  task automatic model_bit(input logic b, output logic h);
    stream.push_back(b);
    if (stream.size() > PAT_W)
      void'(stream.pop_front());
    h = 1'b0;
    if (stream.size() == PAT_W) begin
      h = 1'b1;
      for (int j = 0; j < PAT_W; j++)
        if (stream[j] != PAT[PAT_W-1-j]) h = 1'b0;
    end
  endtask

  task automatic model_count(input logic h, input logic clr);
    if (clr) begin
      cnt  = h ? 1 : 0;
      cnt2 = h ? 1 : 0;
    end else if (h) begin
      if (cnt < 255) cnt++;
      if (cnt2 < 3)  cnt2++;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    clear_cnt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_flags(1'b1, 1'b0, 1'b0, 1'b0);
    check("word_match_rst", word_match, 1'b0);
    check("bit_out_rst",    bit_out,    1'b0);
    stream.delete();
    cnt  = 0;
    cnt2 = 0;
    check_cnt();
  endtask

  // Starts in an IDLE cycle; ends at the following IDLE cycle with in_valid still high.
  task automatic do_word(input logic [7:0] d, input int clr_at,
                         output logic [7:0] obs_mask, output logic obs_wm);
    logic [7:0] hits;
    logic       h;
    logic       wm;
    for (int i = 0; i < 8; i++) begin
      model_bit(d[7-i], h);
      hits[i] = h;
    end
    in_valid  = 1'b1;
    in_data   = d;
    clear_cnt = (clr_at == 0);
    obs_mask  = '0;
    obs_wm    = 1'b0;
    wm        = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      h = (k >= 2 && k <= 9) ? hits[k-2] : 1'b0;
      model_count(h, clr_at == k - 1);
      if (h) wm = 1'b1;
      check_flags(k == 10, k <= 9, k == 9, h);
      check_cnt();
      if (k <= 8) begin
        check("bit_out",  bit_out,  d[8-k]);
        check("bit_out2", bit_out2, d[8-k]);
      end
      if (k == 9) begin
        check("word_match",  word_match,  wm);
        check("word_match2", word_match2, wm);
        obs_wm = word_match;
      end
      if (k >= 2 && k <= 9 && match === 1'b1)
        obs_mask[k-2] = 1'b1;
      if (k <= 9) begin
        in_data   = 8'($urandom);
        clear_cnt = (clr_at == k);
      end else begin
        clear_cnt = 1'b0;
      end
    end
  endtask

  // Accepts d, then interrupts (rst or abort) during the cycle that presents bit at_bit.
  task automatic do_interrupt(input logic [7:0] d, input int at_bit, input bit use_abort);
    logic h;
    in_valid  = 1'b1;
    in_data   = d;
    clear_cnt = 1'b0;
    for (int k = 1; k <= at_bit + 1; k++) begin
      @(negedge clk);
      check("busy_mid",    busy,    1'b1);
      check("bit_out_mid", bit_out, d[8-k]);
      in_data = 8'($urandom);
    end
    for (int i = 0; i < at_bit; i++) begin
      model_bit(d[7-i], h);
      model_count(h, 1'b0);
    end
    in_valid = 1'b0;
    if (use_abort) begin
`ifdef PSC_ABORT_EN
      abort = 1'b1;
`endif
    end else begin
      rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
`ifdef PSC_ABORT_EN
    abort = 1'b0;
`endif
    stream.delete();
    if (!use_abort) begin
      cnt  = 0;
      cnt2 = 0;
      check("word_match_int", word_match, 1'b0);
      check("bit_out_int",    bit_out,    1'b0);
    end
    check_flags(1'b1, 1'b0, 1'b0, 1'b0);
    check_cnt();
    for (int g = 0; g < 12; g++) begin
      @(negedge clk);
      check_flags(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  typedef struct {
    bit         do_rst;
    logic [7:0] data;
    int         clr_at;
    logic [7:0] mask;
    logic       wm;
    int         exp_cnt;
    int         exp_cnt2;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] m;
    logic       w;
    int         clr;
    int         gap;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    clear_cnt = 1'b0;
`ifdef PSC_ABORT_EN
    abort     = 1'b0;
`endif

    // mask bit i = hit registered for the i-th scanned bit of the word (time order)
    vecs[0] = '{1'b1, 8'h99, -1, 8'h88, 1'b1, 2, 2};
    vecs[1] = '{1'b0, 8'h99, -1, 8'h88, 1'b1, 4, 3};
    vecs[2] = '{1'b0, 8'h99,  4, 8'h88, 1'b1, 2, 2};
    vecs[3] = '{1'b1, 8'h92, -1, 8'h48, 1'b1, 2, 2};
    vecs[4] = '{1'b1, 8'h01, -1, 8'h00, 1'b0, 0, 0};
    vecs[5] = '{1'b0, 8'h20, -1, 8'h04, 1'b1, 1, 1};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_rst) do_reset();
      do_word(vecs[i].data, vecs[i].clr_at, m, w);
      check("vec_mask",  m,          vecs[i].mask);
      check("vec_wm",    w,          vecs[i].wm);
      check("vec_cnt",   match_cnt,  vecs[i].exp_cnt);
      check("vec_cnt2",  match_cnt2, vecs[i].exp_cnt2);
    end

    in_valid = 1'b0;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      check_flags(1'b1, 1'b0, 1'b0, 1'b0);
    end

    do_interrupt(8'h99, 4, 1'b0);

`ifdef PSC_ABORT_EN
    do_word(8'h99, -1, m, w);
    check("pre_abort_cnt", match_cnt, 2);
    do_interrupt(8'h99, 2, 1'b1);
    check("abort_cnt", match_cnt, 2);
    do_word(8'h39, -1, m, w);
    check("post_abort_mask", m, 8'h80);
    check("post_abort_cnt",  match_cnt, 3);
    in_valid = 1'b0;
    @(negedge clk);
`endif

    for (int n = 0; n < 60; n++) begin
      if (n % 20 == 19) do_reset();
      clr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
      do_word(8'($urandom), clr, m, w);
      gap = int'($urandom_range(0, 2));
      if (gap > 0) begin
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check_flags(1'b1, 1'b0, 1'b0, 1'b0);
          check_cnt();
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
